// File: rtl/instr_mem_loader_pkg.sv
// ============================================================================
// Module      : instr_mem_loader_pkg
// Description : Shared types and constants for the instruction-memory loader.
//               Holds the loader state encoding, the default memory geometry
//               and the NOP encoding returned by the fetch port while loading.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_mem_loader_pkg;

    // Default memory geometry: 32 words of 32 bits, 5-bit word address.
    localparam int WORDS_DEFAULT  = 32;
    localparam int AW_DEFAULT     = 5;

    // Bytes packed into one instruction word (little-endian).
    localparam int BYTES_PER_WORD = 4;

    // Instruction returned while the memory is being rewritten.
    localparam logic [31:0] C_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_word_packer.sv
// ============================================================================
// Module      : instr_word_packer
// Description : Assembles a little-endian byte stream into 32-bit words.
//               The first accepted byte of a word lands in [7:0]. On the
//               fourth accepted byte, word_o carries the complete word and
//               word_valid_o is high in that same cycle, so the consumer can
//               write it on the same edge that accepts the last byte.
// Ports       : clk_i         - clock
//               rst_i         - synchronous active-low reset
//               clear_i       - restart assembly at byte 0
//               byte_accept_i - byte_i is consumed this cycle
//               byte_i        - incoming byte
//               word_o        - assembled word (valid with word_valid_o)
//               word_valid_o  - fourth byte being accepted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_word_packer
    import instr_mem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        byte_accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    localparam logic [1:0] c_last_byte = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  r_cnt;
    logic [23:0] r_asm;   // bytes 0..2 of the word under construction

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cnt <= 2'd0;
            r_asm <= 24'd0;
        end else if (clear_i) begin
            r_cnt <= 2'd0;
            r_asm <= 24'd0;
        end else if (byte_accept_i) begin
            case (r_cnt)
                2'd0:    r_asm[7:0]   <= byte_i;
                2'd1:    r_asm[15:8]  <= byte_i;
                2'd2:    r_asm[23:16] <= byte_i;
                default: ;  // byte 3 goes straight out through word_o
            endcase
            r_cnt <= r_cnt + 2'd1;  // wraps back to 0 after the 4th byte
        end
    end

    // The fourth byte bypasses the register so the word is ready at the
    // accepting edge without an extra cycle of latency.
    assign word_o       = {byte_i, r_asm};
    assign word_valid_o = byte_accept_i && (r_cnt == c_last_byte);

endmodule

`default_nettype wire

// File: rtl/instr_mem_loader.sv
// ============================================================================
// Module      : instr_mem_loader
// Description : Run-time loader for the CPU instruction RAM. Bytes streamed
//               over a valid/ready handshake are packed into words and
//               written sequentially from word 0. The fetch port is
//               combinational and returns NOP while a load is in progress.
// Ports       : clk_i        - clock
//               rst_i        - synchronous active-low reset (clears RAM)
//               start_i      - start a load of len_i words (idle/done only)
//               len_i        - word count 0..WORDS, sampled on start
//               byte_valid_i - byte_i valid
//               byte_i       - program byte, little-endian per word
//               byte_ready_o - byte accepted this cycle when valid
//               busy_o       - load in progress, hold the CPU
//               done_o       - last load completed (sticky)
//               err_o        - last start rejected, len_i > WORDS (sticky)
//               pc_addr_i    - CPU fetch byte address
//               instr_o      - fetched instruction
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int WORDS = WORDS_DEFAULT,
    parameter int AW    = AW_DEFAULT
)(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [5:0]  len_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    input  logic [31:0] pc_addr_i,
    output logic [31:0] instr_o
);

    localparam logic [6:0] c_words = 7'(WORDS);

    loader_state_t r_state;
    loader_state_t w_state_nxt;

    logic [AW-1:0] r_ptr;
    logic [5:0]    r_len;
    logic          r_done;
    logic          r_err;
    logic [31:0]   r_mem [WORDS];

    logic          w_loading;
    logic          w_start_reject;
    logic          w_start_zero;
    logic          w_start_load;
    logic          w_last_word;
    logic [31:0]   w_word;
    logic          w_word_valid;
    logic          w_unused_addr_bits;

    assign w_loading = (r_state == ST_LOAD);

    instr_word_packer u_packer (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (w_start_load),
        .byte_accept_i (byte_valid_i && w_loading),
        .byte_i        (byte_i),
        .word_o        (w_word),
        .word_valid_o  (w_word_valid)
    );

    // Next-state and start decoding.
    always_comb begin
        w_state_nxt    = r_state;
        w_start_reject = 1'b0;
        w_start_zero   = 1'b0;
        w_start_load   = 1'b0;
        w_last_word    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    if ({1'b0, len_i} > c_words) begin
                        w_start_reject = 1'b1;   // state held, RAM untouched
                    end else if (len_i == 6'd0) begin
                        w_start_zero = 1'b1;
                        w_state_nxt  = ST_DONE;
                    end else begin
                        w_start_load = 1'b1;
                        w_state_nxt  = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (w_word_valid && (6'(r_ptr) == r_len - 6'd1)) begin
                    w_last_word = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_len   <= 6'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_reject) begin
                r_err  <= 1'b1;
                r_done <= 1'b0;
            end
            if (w_start_zero) begin
                r_err  <= 1'b0;
                r_done <= 1'b1;
            end
            if (w_start_load) begin
                r_err  <= 1'b0;
                r_done <= 1'b0;
                r_ptr  <= '0;
                r_len  <= len_i;
            end
            if (w_loading && w_word_valid) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_last_word) begin
                r_done <= 1'b1;
            end
        end
    end

    // Instruction RAM; reset wipes every word so an aborted load leaves no
    // partially written program behind.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < WORDS; i++) begin
                r_mem[i] <= C_NOP;
            end
        end else if (w_loading && w_word_valid) begin
            r_mem[r_ptr] <= w_word;
        end
    end

    assign busy_o       = w_loading;
    assign byte_ready_o = w_loading;
    assign done_o       = r_done;
    assign err_o        = r_err;

    // Word-aligned fetch; byte offset and upper bits are don't-care, so the
    // address space wraps modulo the memory size.
    assign instr_o = w_loading ? C_NOP : r_mem[pc_addr_i[AW+1:2]];

    assign w_unused_addr_bits = ^{pc_addr_i[31:AW+2], pc_addr_i[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// ============================================================================
// Module      : tb_instr_mem_loader
// Description : Self-checking bench for instr_mem_loader. A reference array
//               holds the expected RAM image; each load writes bytes 4w..4w+3
//               of the stream into word w, little-endian.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_mem_loader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [5:0]  len_i;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] pc_addr_i;
    logic [31:0] instr_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [32];
    logic [7:0]  byte_q [$];

    always #5 clk_i = ~clk_i;

    instr_mem_loader #(.WORDS(32), .AW(5)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .len_i        (len_i),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .byte_ready_o (byte_ready_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .pc_addr_i    (pc_addr_i),
        .instr_o      (instr_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drives one load of len words from byte_q. mode: 0 valid always high,
    // 1 valid toggles 1,0,1,0, 2 random valid. Optionally pulses start_i
    // during the load (must be ignored).
    task automatic run_load(input int len, input int mode, input bit pulse_start,
                            output int busy_cycles);
        int n;
        int idx;
        int cyc;
        bit v;
        n = len * 4;
        idx = 0;
        cyc = 0;
        busy_cycles = 0;
        start_i = 1'b1;
        len_i = 6'(len);
        tick();
        start_i = 1'b0;
        while (idx < n && cyc < n * 8 + 20) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            byte_valid_i = v;
            byte_i = byte_q[idx];
            if (pulse_start) begin
                start_i = ($urandom_range(0, 7) == 0);
                len_i = 6'($urandom_range(0, 63));
            end
            pc_addr_i = $urandom();
            #1;
            if (busy_o === 1'b1) busy_cycles++;
            checks++;
            if (busy_o !== 1'b1 || byte_ready_o !== 1'b1 || instr_o !== 32'h0) begin
                errors++;
                $display("FAIL load_hold: busy=%b ready=%b instr=%h, required busy=1 ready=1 instr=0 (byte %0d)",
                         busy_o, byte_ready_o, instr_o, idx);
            end
            tick();
            if (v) idx++;
            cyc++;
        end
        byte_valid_i = 1'b0;
        start_i = 1'b0;
        if (idx < n) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: consumed %0d bytes, required %0d", idx, n);
        end
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b1 || err_o !== 1'b0 || byte_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL load_end: busy=%b done=%b err=%b ready=%b, required 0 1 0 0",
                     busy_o, done_o, err_o, byte_ready_o);
        end
        for (int w = 0; w < len; w++) begin
            ref_mem[w] = {byte_q[4*w+3], byte_q[4*w+2], byte_q[4*w+1], byte_q[4*w]};
        end
    endtask

    task automatic test_reset();
        logic [31:0] addrs [3];
        addrs[0] = 32'd0;
        addrs[1] = 32'd4;
        addrs[2] = 32'd124;
        rst_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        for (int w = 0; w < 32; w++) ref_mem[w] = 32'h0;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 || byte_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b done=%b err=%b ready=%b, required all 0",
                     busy_o, done_o, err_o, byte_ready_o);
        end
        for (int i = 0; i < 3; i++) begin
            pc_addr_i = addrs[i];
            #1;
            checks++;
            if (instr_o !== 32'h0) begin
                errors++;
                $display("FAIL reset_fetch: addr=%h instr=%h, required 0", addrs[i], instr_o);
            end
        end
        // Bytes offered while idle must be ignored.
        byte_valid_i = 1'b1;
        byte_i = 8'hA5;
        tick();
        tick();
        byte_valid_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || byte_ready_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_bytes: busy=%b ready=%b done=%b, required 0 0 0",
                     busy_o, byte_ready_o, done_o);
        end
    endtask

    task automatic test_load_basic(input int mode, input int exp_busy);
        int bc;
        byte_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(2, mode, 1'b0, bc);
        checks++;
        if (bc !== exp_busy) begin
            errors++;
            $display("FAIL busy_cycles: mode=%0d got %0d, required %0d", mode, bc, exp_busy);
        end
        pc_addr_i = 32'd0;
        #1;
        checks++;
        if (instr_o !== 32'h12345678) begin
            errors++;
            $display("FAIL basic_word0: mode=%0d got %h, required 12345678", mode, instr_o);
        end
        pc_addr_i = 32'd4;
        #1;
        checks++;
        if (instr_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_word1: mode=%0d got %h, required deadbeef", mode, instr_o);
        end
        pc_addr_i = 32'd8;
        #1;
        checks++;
        if (instr_o !== ref_mem[2]) begin
            errors++;
            $display("FAIL basic_word2: mode=%0d got %h, required %h", mode, instr_o, ref_mem[2]);
        end
    endtask

    task automatic test_errors();
        start_i = 1'b1;
        len_i = 6'd33;
        tick();
        start_i = 1'b0;
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL len33: err=%b busy=%b done=%b, required 1 0 0", err_o, busy_o, done_o);
        end
        start_i = 1'b1;
        len_i = 6'd63;
        tick();
        start_i = 1'b0;
        tick();
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL len63: err=%b busy=%b, required 1 0", err_o, busy_o);
        end
        for (int w = 0; w < 2; w++) begin
            pc_addr_i = 32'(w * 4);
            #1;
            checks++;
            if (instr_o !== ref_mem[w]) begin
                errors++;
                $display("FAIL err_mem: word %0d got %h, required %h", w, instr_o, ref_mem[w]);
            end
        end
        start_i = 1'b1;
        len_i = 6'd0;
        tick();
        start_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || err_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL len0: done=%b err=%b busy=%b, required 1 0 0", done_o, err_o, busy_o);
        end
        pc_addr_i = 32'd4;
        #1;
        checks++;
        if (instr_o !== ref_mem[1]) begin
            errors++;
            $display("FAIL len0_mem: got %h, required %h", instr_o, ref_mem[1]);
        end
    endtask

    task automatic test_full_load();
        int bc;
        byte_q.delete();
        for (int n = 0; n < 32; n++) begin
            byte_q.push_back(8'(n));
            byte_q.push_back(8'h00);
            byte_q.push_back(8'h00);
            byte_q.push_back(8'h00);
        end
        run_load(32, 0, 1'b0, bc);
        for (int n = 0; n < 32; n++) begin
            pc_addr_i = 32'(4 * n);
            #1;
            checks++;
            if (instr_o !== 32'(n)) begin
                errors++;
                $display("FAIL full_word: n=%0d got %h, required %h", n, instr_o, 32'(n));
            end
        end
        pc_addr_i = 32'd128;
        #1;
        checks++;
        if (instr_o !== 32'd0) begin
            errors++;
            $display("FAIL wrap128: got %h, required 0", instr_o);
        end
        pc_addr_i = 32'd5;
        #1;
        checks++;
        if (instr_o !== 32'd1) begin
            errors++;
            $display("FAIL addr5: got %h, required 1", instr_o);
        end
        pc_addr_i = 32'h8000_0084;
        #1;
        checks++;
        if (instr_o !== 32'd1) begin
            errors++;
            $display("FAIL upper_bits: got %h, required 1", instr_o);
        end
    endtask

    task automatic test_random_loads();
        int bc;
        int len;
        logic [31:0] pc;
        for (int it = 0; it < 5; it++) begin
            len = $urandom_range(1, 32);
            byte_q.delete();
            for (int b = 0; b < len * 4; b++) byte_q.push_back(8'($urandom()));
            run_load(len, 2, 1'b1, bc);
            for (int w = 0; w < 32; w++) begin
                pc = $urandom();
                pc[6:2] = 5'(w);
                pc_addr_i = pc;
                #1;
                checks++;
                if (instr_o !== ref_mem[w]) begin
                    errors++;
                    $display("FAIL rand_word: iter %0d len %0d addr %h got %h, required %h",
                             it, len, pc, instr_o, ref_mem[w]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int bc;
        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        start_i = 1'b1;
        len_i = 6'd2;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            byte_valid_i = 1'b1;
            byte_i = byte_q[i];
            tick();
        end
        byte_valid_i = 1'b0;
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        for (int w = 0; w < 32; w++) ref_mem[w] = 32'h0;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 || byte_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_flags: busy=%b done=%b err=%b ready=%b, required all 0",
                     busy_o, done_o, err_o, byte_ready_o);
        end
        for (int w = 0; w < 3; w++) begin
            pc_addr_i = 32'(4 * w);
            #1;
            checks++;
            if (instr_o !== 32'h0) begin
                errors++;
                $display("FAIL midrst_mem: word %0d got %h, required 0", w, instr_o);
            end
        end
        byte_q = '{8'h0D, 8'hF0, 8'hAD, 8'h0B};
        run_load(1, 0, 1'b0, bc);
        for (int w = 0; w < 2; w++) begin
            pc_addr_i = 32'(4 * w);
            #1;
            checks++;
            if (instr_o !== ref_mem[w]) begin
                errors++;
                $display("FAIL reload_word: word %0d got %h, required %h", w, instr_o, ref_mem[w]);
            end
        end
    endtask

    initial begin
        rst_i = 1'b0;
        start_i = 1'b0;
        len_i = 6'd0;
        byte_valid_i = 1'b0;
        byte_i = 8'h00;
        pc_addr_i = 32'd0;
        test_reset();
        test_load_basic(0, 8);
        test_load_basic(1, 15);
        test_errors();
        test_full_load();
        test_random_loads();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
